// File: rtl/char_text_buffer_pkg.sv
// Shared text-mode constants: grid geometry, fill code, control bytes and FSM states.
package char_text_buffer_pkg;

  localparam int unsigned TEXT_COLS = 16;
  localparam int unsigned TEXT_ROWS = 16;
  localparam logic [6:0]  FILL_CHAR = 7'h20;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } text_state_t;

endpackage

// File: rtl/char_text_buffer_ram.sv
// 256x7 simple dual-port RAM: one write port, one registered read-first read port.
module text_ram #(
  parameter int unsigned DATA_W = 7,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Reading the array before this edge's write lands gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/char_text_buffer.sv
// 16x16 text character store: byte-stream writer with cursor/control codes, 1-cycle read port.
module char_text_buffer #(
  parameter int unsigned TEXT_COLS = char_text_buffer_pkg::TEXT_COLS,
  parameter int unsigned TEXT_ROWS = char_text_buffer_pkg::TEXT_ROWS,
  parameter logic [6:0]  FILL_CHAR = char_text_buffer_pkg::FILL_CHAR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  output logic [6:0] char_code,
  output logic [3:0] char_line_d,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] cursor_xy,
  output logic       busy
);
  import char_text_buffer_pkg::*;

  localparam logic [7:0] CLR_LAST = 8'(TEXT_COLS * TEXT_ROWS - 1);

  text_state_t state_q, state_d;
  logic [7:0]  cursor_q, cursor_d;
  logic [7:0]  clr_addr_q, clr_addr_d;
  logic        wr_ready_q;
  logic [3:0]  char_line_q;
  logic        ram_we;
  logic [7:0]  ram_waddr;
  logic [6:0]  ram_wdata;

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = cursor_q;
    ram_wdata  = wr_data[6:0];
    case (state_q)
      CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = FILL_CHAR;
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == CLR_LAST) state_d = IDLE;
      end
      default: begin
        if (wr_valid && wr_ready_q) begin
          if (wr_data >= 8'h20 && wr_data <= 8'h7E) begin
            ram_we   = 1'b1;
            cursor_d = cursor_q + 8'd1;
          end else begin
            case (wr_data)
              ASCII_CR: cursor_d = {cursor_q[7:4], 4'h0};
              ASCII_LF: cursor_d = {cursor_q[7:4] + 4'h1, 4'h0};
              ASCII_BS: begin
                cursor_d  = cursor_q - 8'd1;
                ram_we    = 1'b1;
                ram_waddr = cursor_q - 8'd1;
                ram_wdata = FILL_CHAR;
              end
              ASCII_FF: begin
                cursor_d   = 8'h00;
                clr_addr_d = 8'h00;
                state_d    = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cursor_q    <= 8'h00;
      clr_addr_q  <= 8'h00;
      wr_ready_q  <= 1'b0;
      char_line_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      clr_addr_q  <= clr_addr_d;
      wr_ready_q  <= (state_d == IDLE);
      char_line_q <= char_line;
    end
  end

  // Writes are suppressed during reset so a mid-stream reset cannot land a stray byte.
  text_ram #(.DATA_W(7), .ADDR_W(8)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we && !rst),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (char_xy),
    .rdata_o (char_code)
  );

  assign char_line_d = char_line_q;
  assign wr_ready    = wr_ready_q;
  assign busy        = ~wr_ready_q;
  assign cursor_xy   = cursor_q;

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: reset sweep, cursor/control codes, collision, form feed.
module tb_char_text_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [6:0] char_code;
  logic [3:0] char_line_d;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] cursor_xy;
  logic       busy;

  int checks = 0;
  int errors = 0;

  char_text_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .char_xy     (char_xy),
    .char_line   (char_line),
    .char_code   (char_code),
    .char_line_d (char_line_d),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .cursor_xy   (cursor_xy),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for wr_ready, presents one byte for exactly one accepting edge.
  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!wr_ready && n < 1000) begin
      tick();
      n++;
    end
    if (!wr_ready) chk("send_ready_timeout", 32'(wr_ready), 32'd1);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [6:0] exp);
    logic [3:0] ln;
    ln        = a[3:0] ^ 4'h9;
    char_xy   = a;
    char_line = ln;
    tick();
    chk(tag, 32'(char_code), 32'(exp));
    chk({tag, "_line"}, 32'(char_line_d), 32'(ln));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; char_xy = 8'h00; char_line = 4'h5; wr_data = 8'h00; wr_valid = 1'b0;
    repeat (3) tick();
    chk("rst_char_code", 32'(char_code), 32'h0);
    chk("rst_line_d", 32'(char_line_d), 32'h0);
    chk("rst_cursor", 32'(cursor_xy), 32'h0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(wr_ready), 32'd0);

    rst = 1'b0;
    cnt = 0;
    while (!wr_ready && cnt < 400) begin
      tick();
      cnt++;
    end
    chk("clear_cycles", 32'(cnt), 32'd256);
    chk("idle_busy", 32'(busy), 32'd0);
    read_chk("clr_rd00", 8'h00, 7'h20);
    read_chk("clr_rd7F", 8'h7F, 7'h20);
    read_chk("clr_rdFF", 8'hFF, 7'h20);

    send(8'h41);
    chk("A_cursor", 32'(cursor_xy), 32'h01);
    read_chk("A_ram00", 8'h00, 7'h41);

    for (int i = 0; i < 256; i++) send(8'h42);
    chk("B_wrap_cursor", 32'(cursor_xy), 32'h01);
    read_chk("B_ram00", 8'h00, 7'h42);
    read_chk("B_ramFF", 8'hFF, 7'h42);

    send(8'h0A); send(8'h0A); send(8'h0A);
    chk("lf_to_30", 32'(cursor_xy), 32'h30);
    for (int i = 0; i < 10; i++) send(8'h43);
    chk("at_3A", 32'(cursor_xy), 32'h3A);
    send(8'h0D);
    chk("cr_3A", 32'(cursor_xy), 32'h30);
    send(8'h0A);
    chk("lf_30", 32'(cursor_xy), 32'h40);
    for (int i = 0; i < 11; i++) send(8'h0A);
    chk("lf_to_F0", 32'(cursor_xy), 32'hF0);
    for (int i = 0; i < 5; i++) send(8'h7E);
    chk("at_F5", 32'(cursor_xy), 32'hF5);
    read_chk("tilde_F4", 8'hF4, 7'h7E);
    send(8'h0A);
    chk("lf_wrap", 32'(cursor_xy), 32'h00);

    send(8'h08);
    chk("bs_cursor", 32'(cursor_xy), 32'hFF);
    read_chk("bs_ramFF", 8'hFF, 7'h20);
    send(8'h7F);
    send(8'h01);
    send(8'hC1);
    chk("other_codes", 32'(cursor_xy), 32'hFF);
    read_chk("other_ramFF", 8'hFF, 7'h20);

    send(8'h61);
    chk("wrap_FF", 32'(cursor_xy), 32'h00);
    for (int i = 0; i < 5; i++) send(8'h62);
    chk("at_05", 32'(cursor_xy), 32'h05);
    char_xy  = 8'h05;
    wr_data  = 8'h51;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("coll_old", 32'(char_code), 32'h42);
    chk("coll_cursor", 32'(cursor_xy), 32'h06);
    tick();
    chk("coll_new", 32'(char_code), 32'h51);

    for (int i = 0; i < 256; i++) send(8'h5A);
    read_chk("Z_ram05", 8'h05, 7'h5A);
    read_chk("Z_ramC3", 8'hC3, 7'h5A);
    send(8'h0C);
    chk("ff_cursor", 32'(cursor_xy), 32'h00);
    chk("ff_busy", 32'(busy), 32'd1);
    wr_data  = 8'h57;
    wr_valid = 1'b1;
    cnt = 1;
    tick();
    while (!wr_ready && cnt < 400) begin
      tick();
      cnt++;
    end
    wr_valid = 1'b0;
    chk("ff_clear_cycles", 32'(cnt), 32'd256);
    chk("ff_cursor_after", 32'(cursor_xy), 32'h00);
    read_chk("ff_rd00", 8'h00, 7'h20);
    read_chk("ff_rd05", 8'h05, 7'h20);
    read_chk("ff_rd80", 8'h80, 7'h20);
    read_chk("ff_rdFF", 8'hFF, 7'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
